// File: rtl/snn_pkg.sv
// Shared constants and FSM state type for the SNN sequencer.
// No ports; imported by snn_seq_ctrl and snn_conv_agen.
package snn_pkg;

    localparam int unsigned IMG_W       = 6;
    localparam int unsigned CH          = 3;
    localparam int unsigned FRAMES      = 2;
    localparam int unsigned KER_W       = 3;
    localparam int unsigned CONV_W      = IMG_W - KER_W + 1;
    localparam int unsigned KER_LEN     = KER_W * KER_W;
    localparam int unsigned W_LEN       = 4;
    localparam int unsigned POOL_N      = 4;
    localparam int unsigned FC_N        = 2;
    localparam int unsigned FRAME_BEATS = IMG_W * IMG_W * CH;
    localparam int unsigned TOTAL_BEATS = FRAME_BEATS * FRAMES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_POOL,
        S_FC,
        S_OUT
    } state_t;

endpackage

// File: rtl/snn_conv_agen.sv
// Conv window address generator: walks ch > row > col (col fastest) over
// CH x CONV_W x CONV_W positions, one per cycle, after a start pulse.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a frame; legal when idle or on the done cycle
//   en              a step is issued this cycle
//   done            this cycle issues the last step of the frame
//   ch, row, col    current window position (0 when idle)
module snn_conv_agen
    import snn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       en,
    output logic       done,
    output logic [1:0] ch,
    output logic [1:0] row,
    output logic [1:0] col
);

    logic run;
    logic col_last;
    logic row_last;
    logic ch_last;

    assign col_last = (col == 2'(CONV_W - 1));
    assign row_last = (row == 2'(CONV_W - 1));
    assign ch_last  = (ch  == 2'(CH - 1));
    assign en       = run;
    assign done     = run & ch_last & row_last & col_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            ch  <= '0;
            row <= '0;
            col <= '0;
        end else begin
            if (start) begin
                run <= 1'b1;
            end else if (done) begin
                run <= 1'b0;
            end
            // Counters return to 0 on the last step, ready for a chained start.
            if (run) begin
                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        row <= '0;
                        ch  <= ch_last ? '0 : ch + 2'd1;
                    end else begin
                        row <= row + 2'd1;
                    end
                end else begin
                    col <= col + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/snn_seq_ctrl.sv
// Sequencer for the SNN datapath: counts the img/ker/weight input stream,
// issues buffer write enables, conv window steps, pool and FC steps, and
// pulses out_valid when the result is final. Also drives per-stage
// clock-gate enables.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cg_en                    1 = gate idle stages, 0 = all gate enables held 1
//   in_valid                 input beat valid
//   img_we, img_addr         image write strobe, linear index within frame
//   ker_we, w_we             kernel / weight capture strobes
//   conv_en, conv_frame, conv_ch, conv_row, conv_col   conv step
//   pool_en, pool_idx        pool step ({frame,idx})
//   fc_en, fc_idx            FC step
//   gate_conv/pool/fc        clock-gate enables
//   out_valid                one-cycle result pulse
//   busy                     pattern in progress
//   proto_err                sticky: in_valid seen while not loading
module snn_seq_ctrl
    import snn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cg_en,
    input  logic       in_valid,
    output logic       img_we,
    output logic [7:0] img_addr,
    output logic       ker_we,
    output logic       w_we,
    output logic       conv_en,
    output logic       conv_frame,
    output logic [1:0] conv_ch,
    output logic [1:0] conv_row,
    output logic [1:0] conv_col,
    output logic       pool_en,
    output logic [2:0] pool_idx,
    output logic       fc_en,
    output logic       fc_idx,
    output logic       gate_conv,
    output logic       gate_pool,
    output logic       gate_fc,
    output logic       out_valid,
    output logic       busy,
    output logic       proto_err
);

    state_t     state;
    state_t     state_nx;
    logic [7:0] beat_cnt;
    logic [1:0] frames_loaded;
    logic [1:0] frames_started;
    logic [2:0] pool_cnt;
    logic       fc_cnt;
    logic       conv_frame_q;
    logic       err_q;
    logic       conv_prev;
    logic       pool_prev;
    logic       fc_prev;
    logic       accept;
    logic       last_beat;
    logic       load_evt;
    logic       pend;
    logic       conv_start;
    logic       conv_done;
    logic       conv_run;
    logic       drain_exit;

    // The first beat is accepted in IDLE itself (it is what starts LOAD),
    // so no data is lost on the transition.
    assign accept    = in_valid & ((state == S_IDLE) | (state == S_LOAD));
    assign last_beat = accept & (beat_cnt == 8'(TOTAL_BEATS - 1));
    assign img_addr  = beat_cnt % 8'(FRAME_BEATS);
    assign load_evt  = accept & (img_addr == 8'(FRAME_BEATS - 1));
    assign img_we    = accept;
    assign ker_we    = accept & (beat_cnt < 8'(KER_LEN));
    assign w_we      = accept & (beat_cnt < 8'(W_LEN));

    // A frame is ready either this cycle or from an earlier load still
    // waiting on the previous frame's conv to finish.
    assign pend       = load_evt | (frames_loaded != frames_started);
    assign conv_start = pend & (~conv_run | conv_done);
    assign drain_exit = (state == S_DRAIN) & (state_nx == S_POOL);

    snn_conv_agen u_agen (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .en    (conv_run),
        .done  (conv_done),
        .ch    (conv_ch),
        .row   (conv_row),
        .col   (conv_col)
    );

    assign conv_en    = conv_run;
    assign conv_frame = conv_run & conv_frame_q;
    assign pool_idx   = pool_cnt;
    assign fc_idx     = fc_cnt;
    assign proto_err  = err_q;
    assign gate_conv  = ~cg_en | conv_run | conv_prev;
    assign gate_pool  = ~cg_en | pool_en  | pool_prev;
    assign gate_fc    = ~cg_en | fc_en    | fc_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pool_en   = 1'b0;
        fc_en     = 1'b0;
        out_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:  if (in_valid) state_nx = S_LOAD;
            S_LOAD:  if (in_valid && beat_cnt == 8'(TOTAL_BEATS - 1)) state_nx = S_DRAIN;
            S_DRAIN: if (conv_done && frames_started == 2'(FRAMES)) state_nx = S_POOL;
            S_POOL: begin
                pool_en = 1'b1;
                if (pool_cnt == 3'(POOL_N * FRAMES - 1)) state_nx = S_FC;
            end
            S_FC: begin
                fc_en = 1'b1;
                if (fc_cnt == 1'(FC_N - 1)) state_nx = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt       <= '0;
            frames_loaded  <= '0;
            frames_started <= '0;
            pool_cnt       <= '0;
            fc_cnt         <= 1'b0;
            conv_frame_q   <= 1'b0;
            err_q          <= 1'b0;
            conv_prev      <= 1'b0;
            pool_prev      <= 1'b0;
            fc_prev        <= 1'b0;
        end else begin
            if (last_beat) begin
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 8'd1;
            end

            if (drain_exit) begin
                frames_loaded  <= '0;
                frames_started <= '0;
            end else begin
                if (load_evt)   frames_loaded  <= frames_loaded + 2'd1;
                if (conv_start) frames_started <= frames_started + 2'd1;
            end

            if (conv_start) conv_frame_q <= frames_started[0];

            pool_cnt  <= (pool_en && state_nx == S_POOL) ? pool_cnt + 3'd1 : '0;
            fc_cnt    <= (fc_en && state_nx == S_FC) ? ~fc_cnt : 1'b0;
            err_q     <= err_q | (in_valid & ~accept);
            conv_prev <= conv_run;
            pool_prev <= pool_en;
            fc_prev   <= fc_en;
        end
    end

endmodule
